alu_vector_sequencer: RTL

Requester-side driver for the 32-bit ALU interface (ALUControl/A/B out, ALUResult/Zero in). Holds a buffer of operation vectors with expected results, loaded by a host. On Start it issues each vector to the ALU, waits a settle window, then samples and checks the response. Used for on-chip ALU self-test and as the reusable stimulus/check engine in place of hand-timed benches.

---
 rtl/alu_vector_sequencer_if.sv | 11 +
 rtl/alu_vector_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_vector_sequencer_if.sv
// ALU request/response bus between the vector sequencer (master) and the ALU under test (slave).
interface alu_vector_sequencer_if;
    logic [3:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUResult;
    logic        Zero;

    modport master (output ALUControl, A, B, input ALUResult, Zero);
    modport slave  (input ALUControl, A, B, output ALUResult, Zero);
endinterface

// File: rtl/alu_vector_sequencer.sv
// Vector buffer + issue/settle/check engine for a 32-bit ALU. Optional macro
// ALU_SEQ_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module alu_vector_sequencer #(
    parameter  int DEPTH  = 16,
    parameter  int SETTLE = 2,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          LoadEn,
    input  logic [3:0]    LoadCtrl,
    input  logic [31:0]   LoadA,
    input  logic [31:0]   LoadB,
    input  logic [31:0]   LoadExpResult,
    input  logic          LoadExpZero,
    input  logic          Clear,
    input  logic          Start,
    output logic          Full,
    output logic          Busy,
    output logic          Done,
    alu_vector_sequencer_if.master alu,
    output logic [CW-1:0] VecCount,
    output logic [CW-1:0] PassCount,
    output logic [CW-1:0] FailCount,
    output logic          FailValid,
    output logic [CW-1:0] FirstFailIdx
);
    localparam int IW  = $clog2(DEPTH);
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

    logic [3:0]  mem_ctrl [DEPTH];
    logic [31:0] mem_a    [DEPTH];
    logic [31:0] mem_b    [DEPTH];
    logic [31:0] mem_exp  [DEPTH];
    logic        mem_expz [DEPTH];

    state_t          state_q, state_d;
    logic [CW-1:0]   vec_cnt_q, vec_cnt_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   pass_q, pass_d;
    logic [CW-1:0]   fail_q, fail_d;
    logic            fv_q, fv_d;
    logic [CW-1:0]   ffi_q, ffi_d;
    logic [SCW-1:0]  settle_q, settle_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic            wr_en;
    logic            match;
    logic            last;
    logic [IW-1:0]   rd_idx;

    assign rd_idx = rd_ptr_q[IW-1:0];
    assign match  = (alu.ALUResult == mem_exp[rd_idx]) && (alu.Zero == mem_expz[rd_idx]);
    assign last   = (rd_ptr_q == vec_cnt_q - CW'(1));

    always_comb begin
        state_d  = state_q;
        vec_cnt_d = vec_cnt_q;
        rd_ptr_d = rd_ptr_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        fv_d     = fv_q;
        ffi_d    = ffi_q;
        settle_d = settle_q;
        ctrl_d   = ctrl_q;
        a_d      = a_q;
        b_d      = b_q;
        wr_en    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // Start outranks Clear and LoadEn; the losers are simply dropped.
                if (Start) begin
                    pass_d   = '0;
                    fail_d   = '0;
                    fv_d     = 1'b0;
                    ffi_d    = '0;
                    rd_ptr_d = '0;
                    state_d  = (vec_cnt_q != '0) ? S_DRIVE : S_DONE;
                end else if (Clear) begin
                    vec_cnt_d = '0;
                    rd_ptr_d  = '0;
                    pass_d    = '0;
                    fail_d    = '0;
                    fv_d      = 1'b0;
                    ffi_d     = '0;
                    state_d   = S_IDLE;
                end else if (LoadEn && state_q == S_IDLE && !Full) begin
                    wr_en     = 1'b1;
                    vec_cnt_d = vec_cnt_q + CW'(1);
                end
            end
            S_DRIVE: begin
                ctrl_d = mem_ctrl[rd_idx];
                a_d    = mem_a[rd_idx];
                b_d    = mem_b[rd_idx];
                if (SETTLE > 0) begin
                    settle_d = SCW'(SETTLE - 1);
                    state_d  = S_SETTLE;
                end else begin
                    state_d  = S_CHECK;
                end
            end
            S_SETTLE: begin
                if (settle_q == '0) state_d = S_CHECK;
                else                settle_d = settle_q - SCW'(1);
            end
            S_CHECK: begin
                if (match) begin
                    pass_d = pass_q + CW'(1);
                end else begin
                    fail_d = fail_q + CW'(1);
                    if (!fv_q) begin
                        fv_d  = 1'b1;
                        ffi_d = rd_ptr_q;
                    end
                end
`ifdef ALU_SEQ_STOP_ON_FAIL_EN
                if (last || !match) begin
`else
                if (last) begin
`endif
                    state_d = S_DONE;
                end else begin
                    rd_ptr_d = rd_ptr_q + CW'(1);
                    state_d  = S_DRIVE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            vec_cnt_q <= '0;
            rd_ptr_q  <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            fv_q      <= 1'b0;
            ffi_q     <= '0;
            settle_q  <= '0;
            ctrl_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            state_q   <= state_d;
            vec_cnt_q <= vec_cnt_d;
            rd_ptr_q  <= rd_ptr_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            fv_q      <= fv_d;
            ffi_q     <= ffi_d;
            settle_q  <= settle_d;
            ctrl_q    <= ctrl_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    // Buffer storage needs no reset; VecCount alone defines which entries are live.
    always_ff @(posedge Clk) begin
        if (wr_en && !Reset) begin
            mem_ctrl[vec_cnt_q[IW-1:0]] <= LoadCtrl;
            mem_a[vec_cnt_q[IW-1:0]]    <= LoadA;
            mem_b[vec_cnt_q[IW-1:0]]    <= LoadB;
            mem_exp[vec_cnt_q[IW-1:0]]  <= LoadExpResult;
            mem_expz[vec_cnt_q[IW-1:0]] <= LoadExpZero;
        end
    end

    assign Full           = (vec_cnt_q == CW'(DEPTH));
    assign Busy           = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign Done           = (state_q == S_DONE);
    assign VecCount       = vec_cnt_q;
    assign PassCount      = pass_q;
    assign FailCount      = fail_q;
    assign FailValid      = fv_q;
    assign FirstFailIdx   = ffi_q;
    assign alu.ALUControl = ctrl_q;
    assign alu.A          = a_q;
    assign alu.B          = b_q;
endmodule
